// File: rtl/song_loader_pkg.sv
// Shared types and defaults for the UART song loader.
// SONG_LOADER_CHECKSUM_EN adds the CSUM state to the FSM encoding.
package song_loader_pkg;

  localparam logic [7:0] DEF_START_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE   = 8'h42;
  localparam logic [7:0] DEF_NAK_BYTE   = 8'h4E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLOT,
    ST_LEN,
    ST_DATA,
    ST_RESP
`ifdef SONG_LOADER_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap watchdog: counts while enabled, restarts on clear, flags at GAP_CYC-1.
module rx_gap_timer #(
  parameter int GAP_CYC = 120000,
  localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(GAP_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear || !enable) cnt <= '0;
    else if (cnt != LAST)      cnt <= cnt + CW'(1);
  end

  // A byte arriving in the expiry cycle wins over the timeout.
  assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_song_loader.sv
// Framed UART song upload into SLOTS note buffers with ACK/NAK replies and a player read port.
// Define SONG_LOADER_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module uart_song_loader
  import song_loader_pkg::*;
#(
  parameter int         DATA_W     = 5,
  parameter int         DEPTH      = 128,
  parameter int         SLOTS      = 2,
  parameter logic [7:0] START_BYTE = DEF_START_BYTE,
  parameter logic [7:0] ACK_BYTE   = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE   = DEF_NAK_BYTE,
  parameter int         GAP_CYC    = 120000,
  localparam int        SW         = $clog2(SLOTS),
  localparam int        AW         = addr_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  input  logic                host_req,
  input  logic [SW-1:0]       rd_slot,
  input  logic [AW-1:0]       rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [SLOTS*8-1:0]  slot_len,
  output logic [SLOTS-1:0]    slot_valid,
  output logic                load_busy,
  output logic                load_done
);

  localparam int MW = $clog2(SLOTS * DEPTH);

  state_t                 state;
  logic [SW-1:0]          cur_slot;
  logic [7:0]             len;
  logic [7:0]             cnt;
  logic [SLOTS-1:0][7:0]  len_q;
  logic                   host_pend;
  logic                   gap_en, gap_exp;
  logic                   last_byte, fin_ok, fin_err;
  logic                   wr_en;
  logic [MW-1:0]          wr_idx, rd_idx;
  logic [DATA_W-1:0]      mem [SLOTS*DEPTH];
`ifdef SONG_LOADER_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  assign slot_len  = len_q;
  assign last_byte = (cnt == len - 8'd1);

`ifdef SONG_LOADER_CHECKSUM_EN
  assign gap_en = (state == ST_SLOT) || (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
`else
  assign gap_en = (state == ST_SLOT) || (state == ST_LEN) || (state == ST_DATA);
`endif

  rx_gap_timer #(.GAP_CYC(GAP_CYC)) u_gap (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (gap_en),
    .clear   (rx_valid),
    .expired (gap_exp)
  );

  // Frame termination decode: every exit to RESP goes through fin_ok or fin_err.
  always_comb begin
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    case (state)
      ST_SLOT: fin_err = rx_valid ? (rx_data >= 8'(SLOTS)) : gap_exp;
      ST_LEN:  fin_err = rx_valid ? ((rx_data == 8'd0) || (rx_data > 8'(DEPTH))) : gap_exp;
`ifdef SONG_LOADER_CHECKSUM_EN
      ST_DATA: fin_err = !rx_valid && gap_exp;
      ST_CSUM: begin
        fin_ok  = rx_valid && (rx_data == csum);
        fin_err = rx_valid ? (rx_data != csum) : gap_exp;
      end
`else
      ST_DATA: begin
        fin_ok  = rx_valid && last_byte;
        fin_err = !rx_valid && gap_exp;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_slot   <= '0;
      len        <= '0;
      cnt        <= '0;
      len_q      <= '0;
      slot_valid <= '0;
      host_pend  <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
`ifdef SONG_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      load_done <= 1'b0;
      // One-deep latch; IDLE/RESP clear it below when the ACK is actually issued.
      if (host_req) host_pend <= 1'b1;
      if (fin_ok) begin
        slot_valid[cur_slot] <= 1'b1;
        len_q[cur_slot]      <= len;
        load_done            <= 1'b1;
      end
      if (fin_ok || fin_err) begin
        tx_valid  <= 1'b1;
        tx_data   <= fin_ok ? ACK_BYTE : NAK_BYTE;
        load_busy <= 1'b0;
        state     <= ST_RESP;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_valid && rx_data == START_BYTE) begin
              load_busy <= 1'b1;
              state     <= ST_SLOT;
            end else if (host_req || host_pend) begin
              host_pend <= 1'b0;
              tx_valid  <= 1'b1;
              tx_data   <= ACK_BYTE;
              state     <= ST_RESP;
            end
          end
          ST_SLOT: if (rx_valid) begin
            cur_slot                    <= rx_data[SW-1:0];
            slot_valid[rx_data[SW-1:0]] <= 1'b0;
            len_q[rx_data[SW-1:0]]      <= '0;
            state                       <= ST_LEN;
          end
          ST_LEN: if (rx_valid) begin
            len   <= rx_data;
            cnt   <= '0;
`ifdef SONG_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
            state <= ST_DATA;
          end
          ST_DATA: if (rx_valid) begin
            cnt <= cnt + 8'd1;
`ifdef SONG_LOADER_CHECKSUM_EN
            csum <= csum + rx_data;
            if (last_byte) state <= ST_CSUM;
`endif
          end
          ST_RESP: if (tx_ready) begin
            if (host_pend || host_req) begin
              host_pend <= 1'b0;
              tx_data   <= ACK_BYTE;
            end else begin
              tx_valid <= 1'b0;
              state    <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Flat RAM: slot-major, DEPTH words per slot.
  assign wr_en  = (state == ST_DATA) && rx_valid;
  assign wr_idx = MW'(cur_slot) * MW'(DEPTH) + MW'(cnt[AW-1:0]);
  assign rd_idx = MW'(rd_slot) * MW'(DEPTH) + MW'(rd_addr);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= rx_data[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_idx];
  end

endmodule

// File: tb/tb_uart_song_loader.sv
// Directed bench for uart_song_loader: frame table plus hand sequences for timing corners.
module tb_uart_song_loader;

  localparam int DATA_W = 5;
  localparam int DEPTH  = 128;
  localparam int SLOTS  = 2;
  localparam int GAP    = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b1;
  logic              host_req = 1'b0;
  logic [0:0]        rd_slot = '0;
  logic [6:0]        rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic [15:0]       slot_len;
  logic [1:0]        slot_valid;
  logic              load_busy;
  logic              load_done;

  always #5 clk = ~clk;

  uart_song_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SLOTS(SLOTS), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .host_req(host_req),
    .rd_slot(rd_slot), .rd_addr(rd_addr), .rd_data(rd_data), .slot_len(slot_len),
    .slot_valid(slot_valid), .load_busy(load_busy), .load_done(load_done)
  );

  int         n_run = 0, n_fail = 0;
  int         done_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] fq[$];

  // Transferred response bytes and load_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (load_done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame();
`ifdef SONG_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'd0;
    for (int i = 3; i < fq.size(); i++) s += fq[i];
`endif
    foreach (fq[i]) send(fq[i]);
`ifdef SONG_LOADER_CHECKSUM_EN
    if (fq.size() > 3 && fq.size() == 3 + int'(fq[2])) send(s);
`endif
    fq.delete();
  endtask

  task automatic wait_tx(input string name, input int base, input int lim);
    int n;
    n = 0;
    while (txq.size() <= base && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (txq.size() <= base) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: no response within %0d cycles", name, lim);
    end
  endtask

  task automatic rd_check(input string name, input logic s, input logic [6:0] a, input logic [4:0] exp);
    rd_slot = s;
    rd_addr = a;
    @(negedge clk);
    check(name, rd_data, exp);
  endtask

  typedef struct {
    int              n;
    logic [0:7][7:0] b;
    logic [7:0]      resp;
    logic [1:0]      valid;
    logic [15:0]     lens;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, d0, n;

    tbl[0] = '{6, {8'hA5,8'h00,8'h03,8'h11,8'h12,8'h13,8'h00,8'h00}, 8'h42, 2'b01, 16'h0003};
    tbl[1] = '{2, {8'hA5,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'h4E, 2'b01, 16'h0003};
    tbl[2] = '{3, {8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'h4E, 2'b00, 16'h0000};
    tbl[3] = '{6, {8'hA5,8'h00,8'h03,8'h11,8'h12,8'h13,8'h00,8'h00}, 8'h42, 2'b01, 16'h0003};
    tbl[4] = '{3, {8'hA5,8'h00,8'hC8,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'h4E, 2'b00, 16'h0000};
    tbl[5] = '{3, {8'hA5,8'h00,8'h81,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'h4E, 2'b00, 16'h0000};
    tbl[6] = '{4, {8'hA5,8'h01,8'h01,8'h1F,8'h00,8'h00,8'h00,8'h00}, 8'h42, 2'b10, 16'h0100};

    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_slot_len", slot_len, 0);
    check("rst_slot_valid", slot_valid, 0);
    check("rst_load_busy", load_busy, 0);
    check("rst_load_done", load_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray byte in IDLE is ignored.
    send(8'h33);
    repeat (4) @(negedge clk);
    check("idle_ignore_tx", txq.size(), 0);
    check("idle_ignore_busy", load_busy, 0);

    for (int i = 0; i < 7; i++) begin
      base = txq.size();
      d0   = done_cnt;
      for (int j = 0; j < tbl[i].n; j++) fq.push_back(tbl[i].b[j]);
      send_frame();
      wait_tx($sformatf("vec%0d_wait", i), base, 20);
      if (txq.size() > base) check($sformatf("vec%0d_resp", i), txq[base], tbl[i].resp);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_ntx", i), txq.size(), base + 1);
      check($sformatf("vec%0d_valid", i), slot_valid, tbl[i].valid);
      check($sformatf("vec%0d_len", i), slot_len, tbl[i].lens);
      check($sformatf("vec%0d_done", i), done_cnt - d0, (tbl[i].resp == 8'h42) ? 1 : 0);
      check($sformatf("vec%0d_busy", i), load_busy, 0);
    end

    // Slot0 reload, then 83-byte slot1 load and read-back.
    fq = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h12, 8'h13};
    send_frame();
    repeat (4) @(negedge clk);
    base = txq.size();
    fq = '{8'hA5, 8'h01, 8'd83};
    for (int i = 0; i < 83; i++) fq.push_back(8'(i));
    send_frame();
    wait_tx("long_wait", base, 20);
    if (txq.size() > base) check("long_resp", txq[base], 8'h42);
    repeat (3) @(negedge clk);
    check("long_valid", slot_valid, 2'b11);
    check("long_len", slot_len, 16'h5303);
    for (int a = 0; a < 83; a++) rd_check($sformatf("rd1_%0d", a), 1'b1, 7'(a), 5'(a));
    rd_check("rd0_0", 1'b0, 7'd0, 5'h11);
    rd_check("rd0_1", 1'b0, 7'd1, 5'h12);
    rd_check("rd0_2", 1'b0, 7'd2, 5'h13);

    // Gap timeout mid-payload.
    base = txq.size();
    fq = '{8'hA5, 8'h01, 8'h04, 8'h01};
    send_frame();
    check("gap_busy", load_busy, 1);
    n = 0;
    while (!tx_valid && n < GAP + 20) begin
      @(negedge clk);
      n++;
    end
    check("gap_cycles", n, GAP - 1);
    check("gap_nak", tx_data, 8'h4E);
    repeat (3) @(negedge clk);
    check("gap_ntx", txq.size(), base + 1);
    check("gap_valid", slot_valid, 2'b01);
    check("gap_busy_fall", load_busy, 0);
    base = txq.size();
    fq = '{8'hA5, 8'h01, 8'h01, 8'h07};
    send_frame();
    wait_tx("gap_reload_wait", base, 20);
    if (txq.size() > base) check("gap_reload_resp", txq[base], 8'h42);
    repeat (3) @(negedge clk);
    check("gap_reload_valid", slot_valid, 2'b11);
    rd_check("gap_reload_rd", 1'b1, 7'd0, 5'h07);

    // host_req mid-frame with a stalled TX: frame ACK first, then the queued ACK.
    tx_ready = 1'b0;
    base = txq.size();
    d0   = done_cnt;
    send(8'hA5); send(8'h00); send(8'h03); send(8'h01);
    host_req = 1'b1; @(negedge clk); host_req = 1'b0;
    send(8'h02);
    host_req = 1'b1; @(negedge clk); host_req = 1'b0;
    send(8'h03);
`ifdef SONG_LOADER_CHECKSUM_EN
    send(8'h06);
`endif
    repeat (50) @(negedge clk);
    check("hold_valid", tx_valid, 1);
    check("hold_data", tx_data, 8'h42);
    check("hold_ntx", txq.size(), base);
    tx_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("host_ntx", txq.size(), base + 2);
    if (txq.size() >= base + 2) begin
      check("host_tx0", txq[base], 8'h42);
      check("host_tx1", txq[base + 1], 8'h42);
    end
    check("host_idle", tx_valid, 0);
    check("host_done", done_cnt - d0, 1);

    // host_req in IDLE answers on the next cycle.
    tx_ready = 1'b0;
    host_req = 1'b1; @(negedge clk); host_req = 1'b0;
    check("ping_valid", tx_valid, 1);
    check("ping_data", tx_data, 8'h42);
    base = txq.size();
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ping_ntx", txq.size(), base + 1);
    check("ping_idle", tx_valid, 0);

`ifdef SONG_LOADER_CHECKSUM_EN
    base = txq.size();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h01); send(8'h02); send(8'h03);
    wait_tx("csum_ok_wait", base, 20);
    if (txq.size() > base) check("csum_ok_resp", txq[base], 8'h42);
    repeat (3) @(negedge clk);
    check("csum_ok_valid", slot_valid[0], 1);
    base = txq.size();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h01); send(8'h02); send(8'h04);
    wait_tx("csum_bad_wait", base, 20);
    if (txq.size() > base) check("csum_bad_resp", txq[base], 8'h4E);
    repeat (3) @(negedge clk);
    check("csum_bad_valid", slot_valid[0], 0);
`endif

    // Reset mid-frame discards the frame silently.
    send(8'hA5); send(8'h00);
    base = txq.size();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", load_busy, 0);
    check("mid_rst_valid", slot_valid, 0);
    check("mid_rst_tx", tx_valid, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_ntx", txq.size(), base);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
